// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the synchronous data memory.
// State encoding, wait-counter width and word/offset/index geometry.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int CNT_W          = 4;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 32;
    localparam int BYTES_PER_WORD = DEFAULT_DATA_W / 8;
    localparam int OFFSET_W       = $clog2(BYTES_PER_WORD);
    localparam int IDX_W          = $clog2(DEFAULT_DEPTH);

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int offset_w(input int data_w);
        return (data_w > 8) ? $clog2(data_w / 8) : 0;
    endfunction

    // A one-word array still needs a 1-bit index port.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read port.
// The read register only updates on rd_en_i, so it holds the last read word.
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int IX_W   = idx_w(DEFAULT_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IX_W-1:0]       idx_i,
    input  logic [DATA_W/8-1:0]   byte_we_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  rd_en_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int NB = bytes_per_word(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (byte_we_i[b]) begin
                mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (rd_en_i) begin
            rdata_o <= mem[idx_i];
        end
    end

endmodule

// File: rtl/data_memory_sync.sv
// Word-organised RAM with byte-enable writes, req/ready/done handshake and LATENCY wait states.
// Optional DMEM_BOUNDS_CHECK_EN rejects out-of-range or misaligned accesses with err_o.
module data_memory_sync
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   be_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  err_o
);

    localparam int NB    = bytes_per_word(DATA_W);
    localparam int OFF_W = offset_w(DATA_W);
    localparam int IX_W  = idx_w(DEPTH);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

    dmem_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     be_q;

    logic              accept;
    logic              access;
    logic              access_en;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [NB-1:0]     acc_be;
    logic [ADDR_W-1:0] word_addr;
    logic [IX_W-1:0]   acc_idx;
    logic              acc_err;
    logic [NB-1:0]     byte_we;
    logic              rd_en;

    assign ready_o = (state_q != WAIT);
    assign done_o  = (state_q == RESP);
    assign accept  = req_i & ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_CNT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
        end
    end

    // With zero wait states the access happens on the accept edge itself,
    // so the request is taken straight from the ports.
    assign acc_we    = (LATENCY == 0) ? we_i    : we_q;
    assign acc_addr  = (LATENCY == 0) ? addr_i  : addr_q;
    assign acc_wdata = (LATENCY == 0) ? wdata_i : wdata_q;
    assign acc_be    = (LATENCY == 0) ? be_i    : be_q;

    assign word_addr = acc_addr >> OFF_W;
    assign acc_idx   = word_addr[IX_W-1:0];
    assign access_en = access & ~rst_i;

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
    logic err_q;

    assign acc_err = (word_addr >= ADDR_W'(DEPTH)) || ((acc_addr & OFF_MASK) != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (access_en) begin
            err_q <= acc_err;
        end
    end

    assign err_o = done_o & err_q;
`else
    logic unused_addr_bits;

    assign acc_err          = 1'b0;
    assign err_o            = 1'b0;
    assign unused_addr_bits = ^{word_addr, acc_addr};
`endif

    assign byte_we = {NB{access_en & acc_we & ~acc_err}} & acc_be;
    assign rd_en   = access_en & ~acc_we & ~acc_err;

    dmem_byte_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IX_W   (IX_W)
    ) u_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .idx_i     (acc_idx),
        .byte_we_i (byte_we),
        .wdata_i   (acc_wdata),
        .rd_en_i   (rd_en),
        .rdata_o   (rdata_o)
    );

endmodule

// File: tb/tb_data_memory_sync.sv
// Directed bench for data_memory_sync: one instance with LATENCY=0, one with LATENCY=3.
module tb_data_memory_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst0, req0, we0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic        ready0, done0, err0;
    logic [31:0] rdata0;

    logic        rst3, req3, we3;
    logic [31:0] addr3, wdata3;
    logic [3:0]  be3;
    logic        ready3, done3, err3;
    logic [31:0] rdata3;

    data_memory_sync #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .LATENCY(0)) u_lat0 (
        .clk_i(clk), .rst_i(rst0), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .wdata_i(wdata0), .be_i(be0), .ready_o(ready0), .done_o(done0),
        .rdata_o(rdata0), .err_o(err0)
    );

    data_memory_sync #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .LATENCY(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst3), .req_i(req3), .we_i(we3), .addr_i(addr3),
        .wdata_i(wdata3), .be_i(be3), .ready_o(ready3), .done_o(done3),
        .rdata_o(rdata3), .err_o(err3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
        rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0; be3 = '0;
        step();
        step();
        rst0 = 1'b0;
        rst3 = 1'b0;
        checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL reset_ready0 got=%b exp=1", ready0); end
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done0 got=%b exp=0", done0); end
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset_err0 got=%b exp=0", err0); end
        checks++; if (rdata0 !== 32'h0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
        checks++; if (ready3 !== 1'b1) begin failures++; $display("FAIL reset_ready3 got=%b exp=1", ready3); end
        checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL reset_done3 got=%b exp=0", done3); end
    endtask

    task automatic test_lat0_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'hDEADBEEF; be0 = 4'hF;
        step();
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL lat0_wr_done got=%b exp=1", done0); end
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL lat0_wr_err got=%b exp=0", err0); end
        checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL lat0_wr_ready got=%b exp=1", ready0); end
        we0 = 1'b0; be0 = 4'h0;
        step();
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL lat0_rd_done got=%b exp=1", done0); end
        checks++; if (rdata0 !== 32'hDEADBEEF) begin failures++; $display("FAIL lat0_rd_data got=%h exp=deadbeef", rdata0); end
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL lat0_rd_err got=%b exp=0", err0); end
        req0 = 1'b0;
        step();
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL lat0_idle_done got=%b exp=0", done0); end
        checks++; if (rdata0 !== 32'hDEADBEEF) begin failures++; $display("FAIL lat0_idle_hold got=%h exp=deadbeef", rdata0); end
    endtask

    task automatic test_byte_enable();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; wdata0 = 32'h11223344; be0 = 4'hF;
        step();
        wdata0 = 32'hAABBCCDD; be0 = 4'h5;
        step();
        we0 = 1'b0; be0 = 4'h0;
        step();
        checks++; if (rdata0 !== 32'h11BB33DD) begin failures++; $display("FAIL be_merge got=%h exp=11bb33dd", rdata0); end
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL be_rd_done got=%b exp=1", done0); end
        we0 = 1'b1; wdata0 = 32'hFFFFFFFF; be0 = 4'hF;
        step();
        checks++; if (rdata0 !== 32'h11BB33DD) begin failures++; $display("FAIL be_wr_hold got=%h exp=11bb33dd", rdata0); end
        wdata0 = 32'h00000000; be0 = 4'h0;
        step();
        we0 = 1'b0;
        step();
        checks++; if (rdata0 !== 32'hFFFFFFFF) begin failures++; $display("FAIL be_zero got=%h exp=ffffffff", rdata0); end
        req0 = 1'b0;
        step();
    endtask

`ifdef DMEM_BOUNDS_CHECK_EN
    task automatic test_bounds();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h80; be0 = 4'h0;
        step();
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL oob_rd_done got=%b exp=1", done0); end
        checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL oob_rd_err got=%b exp=1", err0); end
        checks++; if (rdata0 !== 32'hFFFFFFFF) begin failures++; $display("FAIL oob_rd_hold got=%h exp=ffffffff", rdata0); end
        we0 = 1'b1; addr0 = 32'h6; wdata0 = 32'h0; be0 = 4'hF;
        step();
        checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL misalign_wr_err got=%b exp=1", err0); end
        we0 = 1'b0; addr0 = 32'h4;
        step();
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL aligned_rd_err got=%b exp=0", err0); end
        checks++; if (rdata0 !== 32'hFFFFFFFF) begin failures++; $display("FAIL misalign_no_write got=%h exp=ffffffff", rdata0); end
        req0 = 1'b0;
        step();
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL idle_err got=%b exp=0", err0); end
    endtask
`else
    task automatic test_wrap();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h84; wdata0 = 32'h00001234; be0 = 4'hF;
        step();
        we0 = 1'b0; addr0 = 32'h4; be0 = 4'h0;
        step();
        checks++; if (rdata0 !== 32'h00001234) begin failures++; $display("FAIL wrap_rd got=%h exp=00001234", rdata0); end
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b exp=0", err0); end
        addr0 = 32'h8;
        step();
        addr0 = 32'h86;
        step();
        checks++; if (rdata0 !== 32'h00001234) begin failures++; $display("FAIL offset_ignored got=%h exp=00001234", rdata0); end
        req0 = 1'b0;
        step();
    endtask
`endif

    task automatic test_latency3();
        int n;
        req3 = 1'b1; we3 = 1'b1; addr3 = 32'hC; wdata3 = 32'hCAFEF00D; be3 = 4'hF;
        step();
        req3 = 1'b0;
        n = 0;
        while (done3 !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (done3 !== 1'b1) begin failures++; $display("FAIL lat3_wr_timeout got=%b exp=1", done3); end
        step();
        req3 = 1'b1; we3 = 1'b0; be3 = 4'h0;
        step();
        checks++; if (ready3 !== 1'b0) begin failures++; $display("FAIL lat3_wait1_ready got=%b exp=0", ready3); end
        checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL lat3_wait1_done got=%b exp=0", done3); end
        req3 = 1'b0;
        step();
        checks++; if (ready3 !== 1'b0) begin failures++; $display("FAIL lat3_wait2_ready got=%b exp=0", ready3); end
        step();
        checks++; if (ready3 !== 1'b0) begin failures++; $display("FAIL lat3_wait3_ready got=%b exp=0", ready3); end
        checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL lat3_wait3_done got=%b exp=0", done3); end
        req3 = 1'b1;
        step();
        checks++; if (done3 !== 1'b1) begin failures++; $display("FAIL lat3_resp_done got=%b exp=1", done3); end
        checks++; if (ready3 !== 1'b1) begin failures++; $display("FAIL lat3_resp_ready got=%b exp=1", ready3); end
        checks++; if (rdata3 !== 32'hCAFEF00D) begin failures++; $display("FAIL lat3_rd_data got=%h exp=cafef00d", rdata3); end
        step();
        checks++; if (ready3 !== 1'b0) begin failures++; $display("FAIL lat3_b2b_accept got=%b exp=0", ready3); end
        checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL lat3_b2b_done got=%b exp=0", done3); end
        req3 = 1'b0;
        step();
        step();
        checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL lat3_b2b_early got=%b exp=0", done3); end
        step();
        checks++; if (done3 !== 1'b1) begin failures++; $display("FAIL lat3_b2b_done2 got=%b exp=1", done3); end
        step();
        checks++; if (done3 !== 1'b0 || ready3 !== 1'b1) begin failures++; $display("FAIL lat3_back_idle done=%b ready=%b exp=0/1", done3, ready3); end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int seen;
        req3 = 1'b1; we3 = 1'b1; addr3 = 32'hC; wdata3 = 32'h00000055; be3 = 4'hF;
        step();
        req3 = 1'b0;
        rst3 = 1'b1;
        step();
        rst3 = 1'b0;
        checks++; if (ready3 !== 1'b1) begin failures++; $display("FAIL rst_wait_ready got=%b exp=1", ready3); end
        checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL rst_wait_done got=%b exp=0", done3); end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done3 === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rst_dropped_done got=%0d exp=0", seen); end
        req3 = 1'b1; we3 = 1'b0; be3 = 4'h0;
        step();
        req3 = 1'b0;
        n = 0;
        while (done3 !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (done3 !== 1'b1) begin failures++; $display("FAIL rst_rd_timeout got=%b exp=1", done3); end
        checks++; if (rdata3 !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_no_write got=%h exp=cafef00d", rdata3); end
        step();
    endtask

    initial begin
        test_reset();
        test_lat0_write_read();
        test_byte_enable();
`ifdef DMEM_BOUNDS_CHECK_EN
        test_bounds();
`else
        test_wrap();
`endif
        test_latency3();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
